// File: rtl/adq_trig_record_capture.sv
// Triggered record capture for the AC ADC channel stream.
// A trigger edge on the 4-bit vector starts a fixed-length record after a
// programmable delay. Each record is followed by a holdoff gap before the
// next trigger can be accepted. Samples are registered once on the way out.
module adq_trig_record_capture #(
   parameter int NofBits = 16,
   parameter int CntBits = 16
) (
   input  logic               ac_clk1x,
   input  logic               rst_n_i,
   input  logic               arm_i,
   input  logic [CntBits-1:0] trig_delay_i,
   input  logic [CntBits-1:0] rec_len_i,
   input  logic [CntBits-1:0] holdoff_i,
   input  logic [CntBits-1:0] nof_records_i,
   input  logic [3:0]         trigger_vector_i,
   input  logic [NofBits-1:0] ac_data_a_i,
   input  logic [NofBits-1:0] ac_data_az_i,
   input  logic               ac_ovr_a_i,
   input  logic               ac_ovr_az_i,
   output logic [NofBits-1:0] data_a_o,
   output logic [NofBits-1:0] data_az_o,
   output logic               data_dry_o,
   output logic               rec_start_o,
   output logic               rec_end_o,
   output logic               ovr_o,
   output logic               trig_missed_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [CntBits-1:0] rec_count_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      DELAY   = 3'd2,
      CAPTURE = 3'd3,
      HOLDOFF = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t             state_reg;
   logic [3:0]         trig_prev_reg;
   logic               arm_prev_reg;
   logic [CntBits-1:0] delay_cfg_reg;
   logic [CntBits-1:0] len_cfg_reg;
   logic [CntBits-1:0] holdoff_cfg_reg;
   logic [CntBits-1:0] nrec_cfg_reg;
   logic [CntBits-1:0] cnt_reg;
   logic [CntBits-1:0] rec_count_reg;
   logic               ovr_acc_reg;
   logic [NofBits-1:0] data_a_reg;
   logic [NofBits-1:0] data_az_reg;
   logic               data_dry_reg;
   logic               rec_start_reg;
   logic               rec_end_reg;
   logic               ovr_reg;
   logic               trig_missed_reg;
   logic               done_reg;

   logic               trig_event;
   logic               sample_ovr;
   logic               capt_first;
   logic               capt_last;
   logic [CntBits-1:0] count_next;
   logic               last_after_capt;
   logic               last_after_holdoff;

   // A trigger is the first non-zero vector after an all-zero one.
   assign trig_event = (trigger_vector_i != 4'd0) && (trig_prev_reg == 4'd0);
   assign sample_ovr = ac_ovr_a_i | ac_ovr_az_i;
   assign capt_first = (cnt_reg == CntBits'(1));
   assign capt_last  = (cnt_reg == len_cfg_reg);
   // Record counter saturates rather than wrapping in unlimited mode.
   assign count_next = (rec_count_reg == {CntBits{1'b1}}) ? rec_count_reg
                                                          : rec_count_reg + CntBits'(1);
   assign last_after_capt    = (nrec_cfg_reg != '0) && (count_next == nrec_cfg_reg);
   assign last_after_holdoff = (nrec_cfg_reg != '0) && (rec_count_reg == nrec_cfg_reg);

   // Edge-detect history for trigger vector and arm level, tracked in every state.
   always_ff @(posedge ac_clk1x or negedge rst_n_i) begin
      if (!rst_n_i) begin
         trig_prev_reg <= 4'd0;
         arm_prev_reg  <= 1'b0;
      end else begin
         trig_prev_reg <= trigger_vector_i;
         arm_prev_reg  <= arm_i;
      end
   end

   // Capture state machine with registered data and status outputs.
   always_ff @(posedge ac_clk1x or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg       <= IDLE;
         delay_cfg_reg   <= '0;
         len_cfg_reg     <= '0;
         holdoff_cfg_reg <= '0;
         nrec_cfg_reg    <= '0;
         cnt_reg         <= '0;
         rec_count_reg   <= '0;
         ovr_acc_reg     <= 1'b0;
         data_a_reg      <= '0;
         data_az_reg     <= '0;
         data_dry_reg    <= 1'b0;
         rec_start_reg   <= 1'b0;
         rec_end_reg     <= 1'b0;
         ovr_reg         <= 1'b0;
         trig_missed_reg <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         // Per-cycle pulses default low; only CAPTURE raises them.
         data_dry_reg  <= 1'b0;
         rec_start_reg <= 1'b0;
         rec_end_reg   <= 1'b0;
         ovr_reg       <= 1'b0;
         if (!arm_i) begin
            // Abort: partial records are dropped without an end pulse.
            state_reg <= IDLE;
            done_reg  <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (!arm_prev_reg) begin
                     delay_cfg_reg   <= trig_delay_i;
                     len_cfg_reg     <= (rec_len_i == '0) ? CntBits'(1) : rec_len_i;
                     holdoff_cfg_reg <= holdoff_i;
                     nrec_cfg_reg    <= nof_records_i;
                     rec_count_reg   <= '0;
                     trig_missed_reg <= 1'b0;
                     done_reg        <= 1'b0;
                     state_reg       <= ARMED;
                  end
               end
               ARMED: begin
                  if (trig_event) begin
                     cnt_reg   <= CntBits'(1);
                     state_reg <= (delay_cfg_reg == '0) ? CAPTURE : DELAY;
                  end
               end
               DELAY: begin
                  if (trig_event) trig_missed_reg <= 1'b1;
                  if (cnt_reg == delay_cfg_reg) begin
                     cnt_reg   <= CntBits'(1);
                     state_reg <= CAPTURE;
                  end else begin
                     cnt_reg <= cnt_reg + CntBits'(1);
                  end
               end
               CAPTURE: begin
                  if (trig_event) trig_missed_reg <= 1'b1;
                  data_dry_reg  <= 1'b1;
                  data_a_reg    <= ac_data_a_i;
                  data_az_reg   <= ac_data_az_i;
                  rec_start_reg <= capt_first;
                  ovr_acc_reg   <= (capt_first ? 1'b0 : ovr_acc_reg) | sample_ovr;
                  if (capt_last) begin
                     rec_end_reg   <= 1'b1;
                     ovr_reg       <= (capt_first ? 1'b0 : ovr_acc_reg) | sample_ovr;
                     rec_count_reg <= count_next;
                     cnt_reg       <= CntBits'(1);
                     if (holdoff_cfg_reg != '0) begin
                        state_reg <= HOLDOFF;
                     end else if (last_after_capt) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                     end else begin
                        state_reg <= ARMED;
                     end
                  end else begin
                     cnt_reg <= cnt_reg + CntBits'(1);
                  end
               end
               HOLDOFF: begin
                  if (trig_event) trig_missed_reg <= 1'b1;
                  if (cnt_reg == holdoff_cfg_reg) begin
                     if (last_after_holdoff) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                     end else begin
                        state_reg <= ARMED;
                     end
                  end else begin
                     cnt_reg <= cnt_reg + CntBits'(1);
                  end
               end
               DONE: begin
                  done_reg <= 1'b1;
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   assign data_a_o      = data_a_reg;
   assign data_az_o     = data_az_reg;
   assign data_dry_o    = data_dry_reg;
   assign rec_start_o   = rec_start_reg;
   assign rec_end_o     = rec_end_reg;
   assign ovr_o         = ovr_reg;
   assign trig_missed_o = trig_missed_reg;
   assign busy_o        = (state_reg != IDLE) && (state_reg != DONE);
   assign done_o        = done_reg;
   assign rec_count_o   = rec_count_reg;

endmodule
